// File: rtl/spi_reg_ctrl.sv
// ============================================================================
// Module   : spi_reg_ctrl
// Brief    : Frame decoder behind spi_slave: command byte {rw, addr}, then a
//            burst of data bytes to/from the control-register bus with
//            address auto-increment. Optional frame/error statistics are
//            compiled in with SPI_REG_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_reg_ctrl #(
  parameter int         ADDR_W      = 7,
  parameter int         RD_LAT      = 1,
  parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cs,
  input  logic              byte_vld,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
`ifdef SPI_REG_STAT_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_frames,
  output logic [7:0]        stat_err
`endif
);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_cmd     = 3'd1;
  localparam logic [2:0] c_st_wr_data = 3'd2;
  localparam logic [2:0] c_st_rd_wait = 3'd3;
  localparam logic [2:0] c_st_rd_data = 3'd4;

  localparam logic [2:0]        c_rd_lat   = 3'(RD_LAT);
  localparam logic [2:0]        c_cnt_one  = 3'd1;
  localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

  logic [2:0]        r_state;
  logic              r_cs_d;
  logic [2:0]        r_lat_cnt;
  logic [ADDR_W-1:0] r_reg_addr;
  logic [7:0]        r_reg_wdata;
  logic [7:0]        r_tx_byte;
  logic              r_reg_we;
  logic              r_reg_re;
  logic              w_cs_fall;

  assign w_cs_fall = r_cs_d & ~cs;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= c_st_idle;
      r_cs_d      <= 1'b0;
      r_lat_cnt   <= 3'd0;
      r_reg_addr  <= '0;
      r_reg_wdata <= 8'h00;
      r_tx_byte   <= STATUS_BYTE;
      r_reg_we    <= 1'b0;
      r_reg_re    <= 1'b0;
    end else begin
      r_cs_d   <= cs;
      r_reg_we <= 1'b0;
      r_reg_re <= 1'b0;
      // Post-increment lands in the cycle after each write strobe.
      if (r_reg_we) begin
        r_reg_addr <= r_reg_addr + c_addr_one;
      end
      if (cs) begin
        r_state   <= c_st_idle;
        r_tx_byte <= STATUS_BYTE;
        r_lat_cnt <= 3'd0;
      end else begin
        case (r_state)
          c_st_idle: begin
            r_tx_byte <= STATUS_BYTE;
            if (w_cs_fall) begin
              r_state <= c_st_cmd;
            end
          end
          c_st_cmd: begin
            if (byte_vld) begin
              r_reg_addr <= rx_byte[ADDR_W-1:0];
              if (rx_byte[7]) begin
                r_reg_re  <= 1'b1;
                r_lat_cnt <= 3'd0;
                r_state   <= c_st_rd_wait;
              end else begin
                r_state <= c_st_wr_data;
              end
            end
          end
          c_st_wr_data: begin
            if (byte_vld) begin
              r_reg_wdata <= rx_byte;
              r_reg_we    <= 1'b1;
            end
          end
          c_st_rd_wait: begin
            // Counter is 0 in the reg_re cycle; read data is valid at RD_LAT.
            if (r_lat_cnt == c_rd_lat) begin
              r_tx_byte <= reg_rdata;
              r_lat_cnt <= 3'd0;
              r_state   <= c_st_rd_data;
            end else begin
              r_lat_cnt <= r_lat_cnt + c_cnt_one;
            end
          end
          c_st_rd_data: begin
            if (byte_vld) begin
              r_reg_addr <= r_reg_addr + c_addr_one;
              r_reg_re   <= 1'b1;
              r_lat_cnt  <= 3'd0;
              r_state    <= c_st_rd_wait;
            end
          end
          default: begin
            r_state <= c_st_idle;
          end
        endcase
      end
    end
  end

  // Reset also masks a strobe that was already registered when reset arrives.
  assign reg_we    = r_reg_we & ~sys_rst;
  assign reg_re    = r_reg_re & ~sys_rst;
  assign reg_addr  = r_reg_addr;
  assign reg_wdata = r_reg_wdata;
  assign tx_byte   = r_tx_byte;
  assign busy      = ~cs & (r_state != c_st_idle);

`ifdef SPI_REG_STAT_EN
  logic        w_cs_rise;
  logic        r_data_seen;
  logic        r_drop_seen;
  logic [15:0] r_stat_frames;
  logic [7:0]  r_stat_err;

  assign w_cs_rise = ~r_cs_d & cs;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_data_seen   <= 1'b0;
      r_drop_seen   <= 1'b0;
      r_stat_frames <= 16'h0000;
      r_stat_err    <= 8'h00;
    end else begin
      if (cs) begin
        r_data_seen <= 1'b0;
        r_drop_seen <= 1'b0;
      end else if (byte_vld) begin
        if (r_state == c_st_wr_data || r_state == c_st_rd_data) begin
          r_data_seen <= 1'b1;
        end
        if (r_state == c_st_rd_wait) begin
          r_drop_seen <= 1'b1;
        end
      end
      if (stat_clr) begin
        r_stat_frames <= 16'h0000;
        r_stat_err    <= 8'h00;
      end else if (w_cs_rise) begin
        if (r_data_seen) begin
          r_stat_frames <= r_stat_frames + 16'h0001;
        end
        if ((r_state == c_st_cmd || r_drop_seen) && r_stat_err != 8'hFF) begin
          r_stat_err <= r_stat_err + 8'h01;
        end
      end
    end
  end

  assign stat_frames = r_stat_frames;
  assign stat_err    = r_stat_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
// ============================================================================
// Module   : tb_spi_reg_ctrl
// Brief    : Self-checking bench for spi_reg_ctrl with a latency-accurate
//            register bank and frame-level expected results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_reg_ctrl;

  localparam int RD_LAT = 1;
  localparam int GAP    = RD_LAT + 4;

  logic       sys_clk;
  logic       sys_rst;
  logic       cs;
  logic       byte_vld;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
`ifdef SPI_REG_STAT_EN
  logic        stat_clr;
  logic [15:0] stat_frames;
  logic [7:0]  stat_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [128];
  logic [7:0]  rd_pipe [RD_LAT];
  logic [14:0] wr_log [$];
  logic [6:0]  re_log [$];
  int          overlap_cnt = 0;

  spi_reg_ctrl #(.RD_LAT(RD_LAT)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .cs        (cs),
    .byte_vld  (byte_vld),
    .rx_byte   (rx_byte),
    .tx_byte   (tx_byte),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy)
`ifdef SPI_REG_STAT_EN
    ,
    .stat_clr    (stat_clr),
    .stat_frames (stat_frames),
    .stat_err    (stat_err)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Register bank: read data appears exactly RD_LAT cycles after the address.
  always @(posedge sys_clk) begin
    rd_pipe[0] <= mem[reg_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign reg_rdata = rd_pipe[RD_LAT-1];

  always @(negedge sys_clk) begin
    if (reg_we) wr_log.push_back({reg_addr, reg_wdata});
    if (reg_re) re_log.push_back(reg_addr);
    if (reg_we && reg_re) overlap_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_byte(input logic [7:0] b);
    @(posedge sys_clk); #1;
    byte_vld = 1'b1;
    rx_byte  = b;
    @(posedge sys_clk); #1;
    byte_vld = 1'b0;
    rx_byte  = 8'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b);
    pulse_byte(b);
    cycles(GAP);
  endtask

  task automatic frame_start();
    @(posedge sys_clk); #1;
    cs = 1'b0;
    cycles(2);
  endtask

  task automatic frame_end();
    cs = 1'b1;
    cycles(3);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    cycles(3);
    checks++; if (tx_byte !== 8'hA5) begin errors++; $display("FAIL reset_tx: got %h expected a5", tx_byte); end
    checks++; if (reg_addr !== 7'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", reg_addr); end
    checks++; if (reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h expected 00", reg_wdata); end
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", reg_we); end
    checks++; if (reg_re !== 1'b0) begin errors++; $display("FAIL reset_re: got %b expected 0", reg_re); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    sys_rst = 1'b0;
    cycles(2);
  endtask

  task automatic test_write_burst();
    int rb;
    rb = re_log.size();
    frame_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b expected 1", busy); end
    send_byte(8'h05);
    pulse_byte(8'h11);
    checks++; if (reg_we !== 1'b1 || reg_addr !== 7'h05 || reg_wdata !== 8'h11)
      begin errors++; $display("FAIL wr_first: got we=%b addr=%h data=%h expected 1/05/11", reg_we, reg_addr, reg_wdata); end
    cycles(GAP);
    pulse_byte(8'h22);
    checks++; if (reg_we !== 1'b1 || reg_addr !== 7'h06 || reg_wdata !== 8'h22)
      begin errors++; $display("FAIL wr_second: got we=%b addr=%h data=%h expected 1/06/22", reg_we, reg_addr, reg_wdata); end
    cycles(1);
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL wr_pulse_len: got %b expected 0", reg_we); end
    cycles(GAP);
    frame_end();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end: got %b expected 0", busy); end
    checks++; if (re_log.size() != rb) begin errors++; $display("FAIL wr_no_read: got %0d reads expected 0", re_log.size() - rb); end
  endtask

  task automatic test_random_writes();
    for (int it = 0; it < 6; it++) begin
      int unsigned a;
      int unsigned n;
      int wb;
      int rb;
      logic [7:0] d [$];
      a  = $urandom_range(0, 127);
      n  = $urandom_range(1, 6);
      wb = wr_log.size();
      rb = re_log.size();
      if (it == 0) a = 127;
      frame_start();
      send_byte({1'b0, 7'(a)});
      for (int k = 0; k < int'(n); k++) begin
        d.push_back(8'($urandom));
        send_byte(d[k]);
      end
      frame_end();
      checks++;
      if (wr_log.size() - wb != int'(n)) begin
        errors++; $display("FAIL rwr_count: got %0d writes expected %0d", wr_log.size() - wb, n);
      end else begin
        for (int k = 0; k < int'(n); k++) begin
          checks++;
          if (wr_log[wb+k] !== {7'((a + k) % 128), d[k]})
            begin errors++; $display("FAIL rwr_data: got %h expected %h", wr_log[wb+k], {7'((a + k) % 128), d[k]}); end
        end
      end
      checks++; if (re_log.size() != rb) begin errors++; $display("FAIL rwr_no_read: got %0d expected 0", re_log.size() - rb); end
    end
  endtask

  task automatic test_addr_wrap();
    int wb;
    wb = wr_log.size();
    frame_start();
    send_byte(8'h7F);
    send_byte(8'hAA);
    send_byte(8'hBB);
    frame_end();
    checks++;
    if (wr_log.size() - wb != 2) begin
      errors++; $display("FAIL wrap_count: got %0d expected 2", wr_log.size() - wb);
    end else begin
      checks++; if (wr_log[wb] !== {7'h7F, 8'hAA}) begin errors++; $display("FAIL wrap_first: got %h expected %h", wr_log[wb], {7'h7F, 8'hAA}); end
      checks++; if (wr_log[wb+1] !== {7'h00, 8'hBB}) begin errors++; $display("FAIL wrap_second: got %h expected %h", wr_log[wb+1], {7'h00, 8'hBB}); end
    end
  endtask

  task automatic test_read_burst();
    for (int it = 0; it < 6; it++) begin
      int unsigned a;
      int unsigned n;
      int wb;
      int rb;
      a  = $urandom_range(0, 127);
      n  = $urandom_range(1, 4);
      if (it == 0) begin a = 3; n = 2; end
      if (it == 1) a = 126;
      wb = wr_log.size();
      rb = re_log.size();
      frame_start();
      checks++; if (tx_byte !== 8'hA5) begin errors++; $display("FAIL rd_status: got %h expected a5", tx_byte); end
      pulse_byte({1'b1, 7'(a)});
      cycles(2);
      checks++; if (tx_byte !== mem[a]) begin errors++; $display("FAIL rd_first: got %h expected %h", tx_byte, mem[a]); end
      cycles(GAP - 2);
      for (int j = 1; j <= int'(n); j++) begin
        send_byte(8'($urandom));
        checks++;
        if (tx_byte !== mem[(a + j) % 128])
          begin errors++; $display("FAIL rd_next: got %h expected %h", tx_byte, mem[(a + j) % 128]); end
      end
      frame_end();
      checks++;
      if (re_log.size() - rb != int'(n) + 1) begin
        errors++; $display("FAIL rd_re_count: got %0d expected %0d", re_log.size() - rb, n + 1);
      end else begin
        for (int j = 0; j <= int'(n); j++) begin
          checks++;
          if (re_log[rb+j] !== 7'((a + j) % 128))
            begin errors++; $display("FAIL rd_re_addr: got %h expected %h", re_log[rb+j], 7'((a + j) % 128)); end
        end
      end
      checks++; if (wr_log.size() != wb) begin errors++; $display("FAIL rd_no_write: got %0d expected 0", wr_log.size() - wb); end
      checks++; if (tx_byte !== 8'hA5) begin errors++; $display("FAIL rd_idle_tx: got %h expected a5", tx_byte); end
    end
  endtask

  task automatic test_abort();
    int rb;
    rb = re_log.size();
    frame_start();
    pulse_byte(8'h80);
    checks++; if (reg_re !== 1'b1 || reg_addr !== 7'h00) begin errors++; $display("FAIL abort_re: got re=%b addr=%h expected 1/00", reg_re, reg_addr); end
    cs = 1'b1;
    cycles(1);
    checks++; if (reg_re !== 1'b0 || tx_byte !== 8'hA5) begin errors++; $display("FAIL abort_idle: got re=%b tx=%h expected 0/a5", reg_re, tx_byte); end
    cycles(8);
    checks++; if (tx_byte !== 8'hA5) begin errors++; $display("FAIL abort_no_capture: got %h expected a5", tx_byte); end
    checks++; if (re_log.size() - rb != 1) begin errors++; $display("FAIL abort_re_count: got %0d expected 1", re_log.size() - rb); end
  endtask

  task automatic test_rd_wait_violation();
    int unsigned a;
    int rb;
    a  = $urandom_range(0, 127);
    rb = re_log.size();
    frame_start();
    pulse_byte({1'b1, 7'(a)});
    pulse_byte(8'hEE);
    cycles(GAP);
    checks++; if (tx_byte !== mem[a]) begin errors++; $display("FAIL viol_capture: got %h expected %h", tx_byte, mem[a]); end
    checks++; if (re_log.size() - rb != 1) begin errors++; $display("FAIL viol_re_count: got %0d expected 1", re_log.size() - rb); end
    frame_end();
  endtask

  task automatic test_reset_mid_write();
    int wb;
    wb = wr_log.size();
    frame_start();
    send_byte(8'h10);
    pulse_byte(8'h77);
    sys_rst = 1'b1;
    #1;
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL rst_we_same: got %b expected 0", reg_we); end
    @(posedge sys_clk); #1;
    checks++; if (reg_we !== 1'b0 || reg_re !== 1'b0) begin errors++; $display("FAIL rst_strobes: got we=%b re=%b expected 0/0", reg_we, reg_re); end
    checks++; if (tx_byte !== 8'hA5 || reg_addr !== 7'h00 || reg_wdata !== 8'h00 || busy !== 1'b0)
      begin errors++; $display("FAIL rst_outputs: got tx=%h addr=%h wdata=%h busy=%b expected a5/00/00/0", tx_byte, reg_addr, reg_wdata, busy); end
    sys_rst = 1'b0;
    cs      = 1'b1;
    cycles(3);
    checks++; if (wr_log.size() != wb) begin errors++; $display("FAIL rst_no_write: got %0d expected 0", wr_log.size() - wb); end
  endtask

  task automatic test_back_to_back();
    int wb;
    wb = wr_log.size();
    for (int it = 0; it < 4; it++) begin
      frame_start();
      send_byte(8'h40);
      send_byte(8'(it));
      frame_end();
    end
    checks++;
    if (wr_log.size() - wb != 4) begin
      errors++; $display("FAIL b2b_count: got %0d expected 4", wr_log.size() - wb);
    end else begin
      for (int it = 0; it < 4; it++) begin
        checks++;
        if (wr_log[wb+it] !== {7'h40, 8'(it)}) begin errors++; $display("FAIL b2b_data: got %h expected %h", wr_log[wb+it], {7'h40, 8'(it)}); end
      end
    end
    checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d expected 0", overlap_cnt); end
  endtask

`ifdef SPI_REG_STAT_EN
  task automatic test_stats();
    @(posedge sys_clk); #1; stat_clr = 1'b1;
    @(posedge sys_clk); #1; stat_clr = 1'b0;
    checks++; if (stat_frames !== 16'd0 || stat_err !== 8'd0) begin errors++; $display("FAIL stat_clr0: got %0d/%0d expected 0/0", stat_frames, stat_err); end
    frame_start();
    send_byte(8'h20);
    send_byte(8'h55);
    frame_end();
    frame_start();
    frame_end();
    checks++; if (stat_frames !== 16'd1) begin errors++; $display("FAIL stat_frames: got %0d expected 1", stat_frames); end
    checks++; if (stat_err !== 8'd1) begin errors++; $display("FAIL stat_err: got %0d expected 1", stat_err); end
    @(posedge sys_clk); #1; stat_clr = 1'b1;
    @(posedge sys_clk); #1; stat_clr = 1'b0;
    checks++; if (stat_frames !== 16'd0 || stat_err !== 8'd0) begin errors++; $display("FAIL stat_clr1: got %0d/%0d expected 0/0", stat_frames, stat_err); end
  endtask
`endif

  initial begin
    sys_rst  = 1'b1;
    cs       = 1'b1;
    byte_vld = 1'b0;
    rx_byte  = 8'h00;
`ifdef SPI_REG_STAT_EN
    stat_clr = 1'b0;
`endif
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h5A;
    mem[3] = 8'h3C;
    mem[4] = 8'h4D;

    test_reset();
    test_write_burst();
    test_random_writes();
    test_addr_wrap();
    test_read_burst();
    test_abort();
    test_rd_wait_violation();
    test_reset_mid_write();
    test_back_to_back();
`ifdef SPI_REG_STAT_EN
    test_stats();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Frame-level controller behind spi_slave. Consumes the slave's per-byte completion strobe and received byte, and decodes a command/address byte followed by a burst of data bytes.
- Drives a simple internal register bus: write strobes, or read requests with fixed latency.
- Supplies the next transmit byte to the slave.
- Maps the SPI link onto the FPGA control-register bank, with address auto-increment per data byte.

Parameters:
- ADDR_W, 7: register address width; the command byte carries {rw, addr[6:0]}, so ADDR_W is fixed at 7.
- RD_LAT, 1: register-bus read latency in sys_clk cycles, legal range 1..4.
- STATUS_BYTE, 8'hA5: byte returned on MISO while the command byte is being received.

Ports:
- sys_clk  in  1  system clock; all logic is on its rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- cs  in  1  chip select, active-low, already synchronised to sys_clk upstream.
- byte_vld  in  1  one-cycle pulse from spi_slave when a byte completes.
- rx_byte  in  8  received byte, valid when byte_vld=1.
- tx_byte  out  8  byte loaded by spi_slave for the next transfer.
- reg_addr  out  7  register-bus address.
- reg_wdata  out  8  register-bus write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data, valid exactly RD_LAT cycles after reg_re.
- busy  out  1  high while a frame is open (cs=0 and state is not IDLE).

Behaviour:
- Reset (sys_rst=1 at a clock edge):
  - state=IDLE, tx_byte=STATUS_BYTE, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0.
  - The latency counter is cleared.
  - Reset mid-frame discards everything; no strobe is issued in the reset cycle or the cycle after it.
- States: IDLE, CMD, WR_DATA, RD_WAIT, RD_DATA.
- IDLE:
  - tx_byte=STATUS_BYTE.
  - Falling edge of cs (previous 1, current 0) → CMD next cycle.
  - byte_vld in IDLE is ignored.
- CMD, on byte_vld:
  - reg_addr <= rx_byte[6:0].
  - rx_byte[7]=0 (write) → WR_DATA.
  - rx_byte[7]=1 (read) → reg_re=1 for one cycle at the latched address, then RD_WAIT.
- WR_DATA, on byte_vld:
  - reg_wdata <= rx_byte and reg_we=1 for one cycle, both in the cycle after byte_vld.
  - reg_addr increments the cycle after the write strobe, modulo 128 (7'h7F wraps to 7'h00).
  - Remains in WR_DATA.
- RD_WAIT:
  - Counts RD_LAT cycles from the reg_re cycle, then captures reg_rdata into tx_byte → RD_DATA.
  - tx_byte is updated no later than RD_LAT+2 cycles after the triggering byte_vld.
  - The bus master guarantees at least RD_LAT+3 sys_clk cycles between byte_vld and the first SCLK edge of the next byte.
- RD_DATA, on byte_vld:
  - rx_byte is ignored.
  - reg_addr increments (mod 128), reg_re=1 the next cycle → RD_WAIT (prefetch of the next byte).
- cs=1 in any state:
  - → IDLE on the next edge; any pending capture is dropped.
  - reg_we/reg_re already asserted in that cycle are not retracted.
  - The latency counter is cleared.
- byte_vld and cs rising in the same cycle: the byte is ignored and the state goes to IDLE.
- byte_vld arriving in RD_WAIT (timing violation): ignored; capture proceeds as normal.
- reg_we and reg_re are never high in the same cycle.
- A read prefetch past the last byte actually clocked is harmless; the register bank must tolerate speculative reads.

Optional Feature:
- Macro: SPI_REG_STAT_EN.
- When defined, three extra outputs are added:
  - stat_frames[15:0]: increments on every cs rising edge where the frame completed at least one data byte after the command.
  - stat_err[7:0]: increments on a cs rising edge from CMD (empty frame) or with a byte_vld dropped in RD_WAIT; saturates at 8'hFF.
  - stat_clr: input, 1-cycle synchronous clear of both counters; takes priority over an increment in the same cycle.
- Both counters reset to 0 on sys_rst.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Write burst: cs low, bytes 8'h05, 8'h11, 8'h22 → reg_we pulses with addr 5 / data 8'h11, then addr 6 / data 8'h22; reg_re never asserted; busy=0 after cs high.
- Read burst, RD_LAT=1, bank holds addr3=8'h3C, addr4=8'h4D: bytes 8'h83, dummy, dummy →
  - tx_byte = 8'hA5 during the command;
  - tx_byte = 8'h3C within 3 cycles of the first byte_vld;
  - tx_byte = 8'h4D after the second byte_vld.
- Address wrap: write command 8'h7F, data 8'hAA, 8'hBB → writes go to addr 7'h7F, then 7'h00.
- Abort: raise cs 1 cycle after the command byte_vld of read 8'h80 → state IDLE next edge, tx_byte=8'hA5, no capture occurs, no further reg_re.
- Reset mid-write: assert sys_rst 1 cycle after a data byte_vld → no reg_we in that or the following cycle, all outputs at reset values.
- With SPI_REG_STAT_EN: one good write frame plus one empty frame → stat_frames=1, stat_err=1; pulse stat_clr → both 0.
